// File: rtl/ibuffer_pkg.sv
// Shared definitions for the per-warp instruction buffer: the decoded
// entry layout (field offsets and packed struct), error flag bit
// positions, and a helper used by decode to pack a lane.
package ibuffer_pkg;

    localparam int ENTRY_W = 46;

    // Field widths
    localparam int SRC_W   = 5;
    localparam int IMME_W  = 16;
    localparam int ALUOP_W = 4;
    localparam int FLAGS_W = 11;

    // Field offsets (LSB of each field), MSB->LSB order
    localparam int SRC1_LSB             = 41;
    localparam int SRC2_LSB             = 36;
    localparam int DST_LSB              = 31;
    localparam int IMME_LSB             = 15;
    localparam int ALUOP_LSB            = 11;
    localparam int NOOP_BIT             = 10;
    localparam int REGWRITE_BIT         = 9;
    localparam int MEMWRITE_BIT         = 8;
    localparam int MEMREAD_BIT          = 7;
    localparam int EXIT_BIT             = 6;
    localparam int SHARED_GLOBALBAR_BIT = 5;
    localparam int SRC1_VALID_BIT       = 4;
    localparam int SRC2_VALID_BIT       = 3;
    localparam int IMME_VALID_BIT       = 2;
    localparam int BEQ_BIT              = 1;
    localparam int BLT_BIT              = 0;

    // Err_IB bit positions
    localparam int ERR_OVERFLOW_BIT  = 1;
    localparam int ERR_BAD_GRANT_BIT = 0;

    typedef struct packed {
        logic [SRC_W-1:0]   src1;
        logic [SRC_W-1:0]   src2;
        logic [SRC_W-1:0]   dst;
        logic [IMME_W-1:0]  imme;
        logic [ALUOP_W-1:0] aluop;
        logic               noop;
        logic               reg_write;
        logic               mem_write;
        logic               mem_read;
        logic               exit_op;
        logic               shared_globalbar;
        logic               src1_valid;
        logic               src2_valid;
        logic               imme_valid;
        logic               beq;
        logic               blt;
    } entry_t;

    // Pack one decode lane; flags are given MSB->LSB (noop .. blt).
    function automatic entry_t pack_entry(
        input logic [SRC_W-1:0]   src1,
        input logic [SRC_W-1:0]   src2,
        input logic [SRC_W-1:0]   dst,
        input logic [IMME_W-1:0]  imme,
        input logic [ALUOP_W-1:0] aluop,
        input logic [FLAGS_W-1:0] flags
    );
        entry_t e;
        e.src1             = src1;
        e.src2             = src2;
        e.dst              = dst;
        e.imme             = imme;
        e.aluop            = aluop;
        e.noop             = flags[NOOP_BIT];
        e.reg_write        = flags[REGWRITE_BIT];
        e.mem_write        = flags[MEMWRITE_BIT];
        e.mem_read         = flags[MEMREAD_BIT];
        e.exit_op          = flags[EXIT_BIT];
        e.shared_globalbar = flags[SHARED_GLOBALBAR_BIT];
        e.src1_valid       = flags[SRC1_VALID_BIT];
        e.src2_valid       = flags[SRC2_VALID_BIT];
        e.imme_valid       = flags[IMME_VALID_BIT];
        e.beq              = flags[BEQ_BIT];
        e.blt              = flags[BLT_BIT];
        return e;
    endfunction

endpackage

// File: rtl/ibuffer_warp_fifo.sv
// One warp's in-order instruction FIFO. Two ordered write ports (lane 0
// stored before lane 1), a pop of the head, and a flush that empties the
// FIFO and discards any same-cycle write. Space is judged against the
// current occupancy, so a same-cycle pop never makes room for a write.
module ibuffer_warp_fifo
    import ibuffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr0_en,
    input  entry_t                 wr0_entry,
    input  logic                   wr1_en,
    input  entry_t                 wr1_entry,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             acc0, acc1, do_pop;
    logic [CNT_W-1:0] count_after0;
    logic [PTR_W-1:0] wr1_ptr;

    // Lane 0 needs a free slot now; lane 1 needs one after lane 0's write.
    assign acc0         = wr0_en && (count_reg != CNT_W'(DEPTH));
    assign count_after0 = count_reg + CNT_W'(acc0);
    assign acc1         = wr1_en && (count_after0 != CNT_W'(DEPTH));
    assign wr1_ptr      = wr_ptr_reg + PTR_W'(acc0);
    assign do_pop       = pop && (count_reg != '0);

    // A write lost for lack of space; flushed writes are wrong-path, not drops.
    assign drop = !flush && ((wr0_en && !acc0) || (wr1_en && !acc1));

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

    // Next pointer/count: flush empties, otherwise apply writes and pop.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(acc0) + PTR_W'(acc1);
            if (do_pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            end
            count_next = count_reg + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(do_pop);
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry storage; not reset, contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (acc0) begin
                mem[wr_ptr_reg] <= wr0_entry;
            end
            if (acc1) begin
                mem[wr1_ptr] <= wr1_entry;
            end
        end
    end

endmodule

// File: rtl/ibuffer.sv
// Per-warp instruction buffer between decode and the warp scheduler.
// Eight (NUM_WARPS) independent FIFOs take up to two decoded entries per
// cycle; the scheduler's one-hot grant selects the head for issue.
// Optional feature macro: IBUFFER_ERR_EN enables the sticky Err_IB flags
// {overflow, bad_grant}; without it Err_IB is tied to zero.
module ibuffer
    import ibuffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int NUM_WARPS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_WARPS-1:0] Valid_IF_ID0_IB,
    input  logic [NUM_WARPS-1:0] Valid_IF_ID1_IB,
    input  logic [ENTRY_W-1:0]   Entry_ID0_IB,
    input  logic [ENTRY_W-1:0]   Entry_ID1_IB,
    input  logic [NUM_WARPS-1:0] Flush_SIMT_IB,
    input  logic [NUM_WARPS-1:0] Grant_SCH_IB,
    output logic [NUM_WARPS-1:0] Ready_IB_SCH,
    output logic                 Issue_Valid_IB_OC,
    output logic [ENTRY_W-1:0]   Issue_Entry_IB_OC,
    output logic [NUM_WARPS-1:0] Full_IB_IF,
    output logic [1:0]           Err_IB
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    entry_t               lane0_entry, lane1_entry;
    entry_t               head_vec  [NUM_WARPS];
    logic [CNT_W-1:0]     count_vec [NUM_WARPS];
    logic [NUM_WARPS-1:0] drop_vec;
    logic [NUM_WARPS-1:0] pop_vec;
    logic                 grant_onehot;
    logic                 issue_valid;
    entry_t               issue_entry;

    assign lane0_entry = entry_t'(Entry_ID0_IB);
    assign lane1_entry = entry_t'(Entry_ID1_IB);

    // A grant issues only if it names exactly one ready, unflushed warp.
    assign grant_onehot = (Grant_SCH_IB != '0) &&
                          ((Grant_SCH_IB & (Grant_SCH_IB - NUM_WARPS'(1))) == '0);
    assign issue_valid  = grant_onehot &&
                          ((Grant_SCH_IB & Ready_IB_SCH & ~Flush_SIMT_IB) != '0);
    assign pop_vec      = Grant_SCH_IB & {NUM_WARPS{issue_valid}};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
            ibuffer_warp_fifo #(
                .DEPTH(DEPTH)
            ) u_fifo (
                .clk       (clk),
                .rst_n     (rst_n),
                .wr0_en    (Valid_IF_ID0_IB[gi]),
                .wr0_entry (lane0_entry),
                .wr1_en    (Valid_IF_ID1_IB[gi]),
                .wr1_entry (lane1_entry),
                .pop       (pop_vec[gi]),
                .flush     (Flush_SIMT_IB[gi]),
                .head      (head_vec[gi]),
                .count     (count_vec[gi]),
                .drop      (drop_vec[gi])
            );

            assign Ready_IB_SCH[gi] = (count_vec[gi] != '0);
            // Two slots stay reserved for instructions already in IF/ID.
            assign Full_IB_IF[gi]   = (count_vec[gi] >= CNT_W'(DEPTH - 2));
        end
    endgenerate

    // Issue mux: OR of heads masked by the (single) popping warp, zero if none.
    always_comb begin
        issue_entry = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (pop_vec[i]) begin
                issue_entry = issue_entry | head_vec[i];
            end
        end
    end

    assign Issue_Valid_IB_OC = issue_valid;
    assign Issue_Entry_IB_OC = issue_entry;

`ifdef IBUFFER_ERR_EN
    logic overflow_reg;
    logic bad_grant_reg;
    logic bad_grant;

    assign bad_grant = (Grant_SCH_IB != '0) &&
                       (!grant_onehot || ((Grant_SCH_IB & Ready_IB_SCH) == '0));

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            bad_grant_reg <= 1'b0;
        end else begin
            if (drop_vec != '0) begin
                overflow_reg <= 1'b1;
            end
            if (bad_grant) begin
                bad_grant_reg <= 1'b1;
            end
        end
    end

    assign Err_IB[ERR_OVERFLOW_BIT]  = overflow_reg;
    assign Err_IB[ERR_BAD_GRANT_BIT] = bad_grant_reg;
`else
    logic unused_drop;
    assign unused_drop = ^drop_vec;
    assign Err_IB      = 2'b00;
`endif

endmodule

// File: tb/tb_ibuffer.sv
// Directed test of ibuffer: issued entries are checked by a scoreboard
// monitor; status outputs are checked directly against hand-derived values.
module tb_ibuffer;
    import ibuffer_pkg::*;

`ifdef IBUFFER_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         v0, v1, flush, grant;
    logic [ENTRY_W-1:0] e0, e1;
    logic [7:0]         ready, full;
    logic               issue_valid;
    logic [ENTRY_W-1:0] issue_entry;
    logic [1:0]         err;

    entry_t exp_q[$];
    int     pass_cnt  = 0;
    int     total_cnt = 0;

    always #5 clk = ~clk;

    ibuffer #(.DEPTH(4), .NUM_WARPS(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .Valid_IF_ID0_IB   (v0),
        .Valid_IF_ID1_IB   (v1),
        .Entry_ID0_IB      (e0),
        .Entry_ID1_IB      (e1),
        .Flush_SIMT_IB     (flush),
        .Grant_SCH_IB      (grant),
        .Ready_IB_SCH      (ready),
        .Issue_Valid_IB_OC (issue_valid),
        .Issue_Entry_IB_OC (issue_entry),
        .Full_IB_IF        (full),
        .Err_IB            (err)
    );

    // Distinct test entry derived from an id.
    function automatic entry_t mk(input int id);
        logic [10:0] fl;
        fl = 11'(id * 37 + 5);
        return pack_entry(5'(id), 5'(id + 3), 5'(id + 7), 16'(16'hA000 + id), 4'(id), fl);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
            $display("check %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic idle();
        v0 = '0; v1 = '0; flush = '0; grant = '0; e0 = '0; e1 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // Scoreboard monitor: every issue must match the oldest expected entry.
    always @(negedge clk) begin
        entry_t e;
        if (rst_n && issue_valid) begin
            total_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_issue: got %0h required no issue", issue_entry);
            end else begin
                e = exp_q.pop_front();
                if (issue_entry === e) begin
                    pass_cnt++;
                    $display("issue: got %0h", issue_entry);
                end else begin
                    $display("FAIL issue_entry: got %0h required %0h", issue_entry, e);
                end
            end
        end
    end

    initial begin
        entry_t ea;
        idle();
        // Reset state
        #3;
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_full", 64'(full), 64'h0);
        check("reset_issue_valid", 64'(issue_valid), 64'h0);
        check("reset_issue_entry", 64'(issue_entry), 64'h0);
        check("reset_err", 64'(err), 64'h0);
        #9 rst_n = 1'b1;
        tick();

        // Single write to warp 2, then issue it
        ea = pack_entry(5'd5, 5'd0, 5'd0, 16'h1234, 4'd0, 11'h0);
        v0 = 8'h04; e0 = ea;
        tick(); idle(); settle();
        check("w2_ready", 64'(ready), 64'h04);
        grant = 8'h04; exp_q.push_back(ea); settle();
        check("w2_issue_valid", 64'(issue_valid), 64'h1);
        check("w2_src1", 64'(issue_entry[SRC1_LSB +: 5]), 64'd5);
        check("w2_imme", 64'(issue_entry[IMME_LSB +: 16]), 64'h1234);
        tick(); idle(); settle();
        check("w2_ready_after", 64'(ready), 64'h0);

        // Dual-lane write to warp 7, ordered A then B; C written during a pop
        v0 = 8'h80; e0 = mk(1); v1 = 8'h80; e1 = mk(2);
        tick(); idle();
        grant = 8'h80; exp_q.push_back(mk(1));
        tick();
        grant = 8'h80; exp_q.push_back(mk(2)); v0 = 8'h80; e0 = mk(3); settle();
        check("w7_issue_valid", 64'(issue_valid), 64'h1);
        tick(); idle(); settle();
        check("w7_ready_c", 64'(ready), 64'h80);
        grant = 8'h80; exp_q.push_back(mk(3));
        tick(); idle(); settle();
        check("w7_ready_empty", 64'(ready), 64'h0);

        // Fill warp 0, overflow, then drain in order
        for (int i = 0; i < 4; i++) begin
            v0 = 8'h01; e0 = mk(10 + i);
            tick(); idle(); settle();
            check("w0_full_bit", 64'(full[0]), (i >= 1) ? 64'h1 : 64'h0);
        end
        v0 = 8'h01; e0 = mk(99);
        tick(); idle(); settle();
        check("w0_ready_full", 64'(ready), 64'h01);
        check("w0_overflow_err", 64'(err), ERR_EN ? 64'h2 : 64'h0);
        for (int i = 0; i < 4; i++) begin
            grant = 8'h01; exp_q.push_back(mk(10 + i));
            tick();
        end
        idle(); settle();
        check("w0_drained_ready", 64'(ready), 64'h0);
        check("w0_drained_full", 64'(full), 64'h0);

        // Flush beats a grant and a write on warp 3
        v0 = 8'h08; e0 = mk(20); v1 = 8'h08; e1 = mk(21);
        tick(); idle(); settle();
        check("w3_ready", 64'(ready), 64'h08);
        flush = 8'h08; grant = 8'h08; v1 = 8'h08; e1 = mk(22); settle();
        check("w3_flush_no_issue", 64'(issue_valid), 64'h0);
        tick(); idle(); settle();
        check("w3_flush_ready", 64'(ready), 64'h0);
        v0 = 8'h08; e0 = mk(23);
        tick(); idle();
        grant = 8'h08; exp_q.push_back(mk(23));
        tick(); idle(); settle();
        check("w3_after_flush_ready", 64'(ready), 64'h0);
        check("w3_err", 64'(err), ERR_EN ? 64'h2 : 64'h0);

        // Bad grants: non-one-hot and empty-warp
        v0 = 8'h02; e0 = mk(30); v1 = 8'h04; e1 = mk(31);
        tick(); idle();
        grant = 8'h06; settle();
        check("multi_grant_valid", 64'(issue_valid), 64'h0);
        check("multi_grant_entry", 64'(issue_entry), 64'h0);
        tick();
        grant = 8'h10; settle();
        check("empty_grant_valid", 64'(issue_valid), 64'h0);
        check("empty_grant_entry", 64'(issue_entry), 64'h0);
        tick(); idle(); settle();
        check("bad_grant_ready", 64'(ready), 64'h06);
        check("bad_grant_err", 64'(err), ERR_EN ? 64'h3 : 64'h0);
        grant = 8'h02; exp_q.push_back(mk(30));
        tick();
        grant = 8'h04; exp_q.push_back(mk(31));
        tick(); idle();

        // Async reset mid-fill of warp 5
        for (int i = 0; i < 3; i++) begin
            v0 = 8'h20; e0 = mk(40 + i);
            tick();
        end
        idle(); #1;
        check("w5_ready_pre_rst", 64'(ready), 64'h20);
        check("w5_full_pre_rst", 64'(full), 64'h20);
        grant = 8'h20; rst_n = 1'b0; #1;
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_full", 64'(full), 64'h0);
        check("rst_issue_valid", 64'(issue_valid), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        tick();
        rst_n = 1'b1; idle();
        tick();
        v0 = 8'h20; e0 = mk(50);
        tick(); idle(); settle();
        check("w5_post_rst_ready", 64'(ready), 64'h20);
        grant = 8'h20; exp_q.push_back(mk(50));
        tick(); idle(); settle();
        check("w5_post_rst_empty", 64'(ready), 64'h0);

        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
